layer_priority_arbiter: RTL and testbench
=========================================

Name: layer_priority_arbiter

Overview:
- Programmable-priority arbiter that shares the single VGA pixel output between NUM_LAYERS drawing objects (smiley/pacman, ghosts, box, hart) and the background.
- Priority table is loaded through a valid/ready config port and takes effect only at the next frame boundary.
- Per-frame overlap detection between layer 0 (player) and every other layer.
- Sits between the object drawing units and the VGA controller; it replaces the fixed-priority mux.

Parameters:
NUM_LAYERS, 4, number of requesting object layers (2..8)
RGB_W, 8, pixel colour width
RANK_W, 3, width of one priority rank field (must satisfy 2^RANK_W >= NUM_LAYERS)

Ports:
clk  in  1  pixel clock
resetN  in  1  asynchronous, active-high reset (asserted = 1)
startOfFrame  in  1  one-cycle pulse at frame start
layerDrawingRequest  in  NUM_LAYERS  bit i = layer i has a pixel here
layerRGB  in  NUM_LAYERS*RGB_W  colour of layer i at bits [i*RGB_W +: RGB_W]
backGroundRGB  in  RGB_W  colour used when no layer requests
cfg_valid  in  1  new priority table offered
cfg_prio  in  NUM_LAYERS*RANK_W  rank of layer i; 0 = highest priority
cfg_ready  out  1  arbiter can accept a table
cfg_error  out  1  one-cycle pulse: offered table rejected
RGBOut  out  RGB_W  arbitrated pixel
winValid  out  1  some layer won this pixel (aligned with RGBOut)
winLayer  out  3  index of winning layer (0 when winValid=0)
collisionFrame  out  NUM_LAYERS-1  bit k-1 = layer 0 overlapped layer k during the previous frame
collisionPulse  out  1  one-cycle pulse at frame boundary if collisionFrame is nonzero

Behaviour:
- Reset: RGBOut=0, winValid=0, winLayer=0, cfg_ready=1, cfg_error=0, collisionFrame=0, collisionPulse=0.
- Reset also clears the pending flag and overlap accumulator, and sets the active table to rank[i]=i.
- Reset mid-frame: all of the above, immediately.

Pipeline (fixed latency 2 cycles):
- Stage 1 registers layerDrawingRequest, layerRGB and backGroundRGB.
- Stage 2 selects and registers the outputs.
- Selection rule: among requesting layers, the lowest rank wins. Ties cannot occur because tables are validated.
- No requester: RGBOut=background, winValid=0.

Config state machine (IDLE, PENDING):
- IDLE: cfg_ready=1. On cfg_valid=1, validate the table.
  - Valid = every rank < NUM_LAYERS and no duplicate ranks.
  - Valid: store in the shadow table, go to PENDING.
  - Invalid: pulse cfg_error on the next cycle, stay in IDLE, active table unchanged.
- PENDING: cfg_ready=0; cfg_valid is ignored.
  - On startOfFrame: copy shadow to active, return to IDLE (cfg_ready=1 next cycle).
- cfg_valid and startOfFrame in the same IDLE cycle: the table is accepted, but the copy waits for the following startOfFrame.
- Table switch timing: the new table governs pixels whose stage-1 sample is taken on or after the cycle after startOfFrame. No pixel is arbitrated with a mixed table.

Collision:
- The accumulator ORs in (req[0] & req[k]) each cycle, using stage-1 registered requests.
- On startOfFrame: collisionFrame <= accumulator | current-cycle overlap, accumulator <= 0.
- collisionPulse=1 for one cycle if the new collisionFrame is nonzero.
- The overlap at the startOfFrame cycle itself belongs to the ending frame.
- collisionFrame holds its value for the whole following frame.

Optional Feature:
LAYER_BLINK_EN
- Defined: adds input blinkMask (NUM_LAYERS) and parameter BLINK_FRAMES (default 8).
- An internal frame counter increments on startOfFrame and wraps at BLINK_FRAMES-1. The blink phase toggles on each wrap; reset gives counter=0, phase=on.
- While phase=off, layers with blinkMask[i]=1 are masked out of arbitration but still count for collision.
- Undefined: no port, no counter; behaviour is exactly as above.

Test Plan:
- After reset, req=4'b0101, RGBs {L0=8'h1C, L2=8'hE0} -> two cycles later RGBOut=8'h1C, winLayer=0, winValid=1; with req=0 -> RGBOut=backGroundRGB, winValid=0.
- Load cfg_prio ranks {3,2,1,0} mid-frame -> cfg_ready drops next cycle; req=4'b1001 -> L0 keeps winning until startOfFrame, then L3 wins; cfg_ready returns to 1.
- cfg_prio ranks {0,0,1,2} -> cfg_error pulses once, cfg_ready stays 1, arbitration unchanged.
- Drive req=4'b0011 for 3 cycles in frame N, none in frame N+1 -> at frame N end collisionFrame=3'b001 and collisionPulse=1; at frame N+1 end collisionFrame=0 and no pulse.
- Assert resetN while PENDING with a collision accumulated -> all outputs are 0, cfg_ready=1, and the default table is active on the first pixel after release.
- (LAYER_BLINK_EN) blinkMask=4'b0001, BLINK_FRAMES=2, req=4'b0011 constant -> L0 wins for frames 0-1, L1 wins for frames 2-3, collision is reported every frame.

Source files
------------

// File: rtl/layer_priority_arbiter_if.sv
// Priority-table configuration port of the layer arbiter.
// master offers a table, slave accepts or rejects it.
interface layer_priority_arbiter_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RANK_W     = 3
);
  logic                         cfg_valid;
  logic [NUM_LAYERS*RANK_W-1:0] cfg_prio;
  logic                         cfg_ready;
  logic                         cfg_error;

  modport master (
    output cfg_valid,
    output cfg_prio,
    input  cfg_ready,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_prio,
    output cfg_ready,
    output cfg_error
  );
endinterface

// File: rtl/layer_priority_arbiter.sv
// Programmable-priority VGA layer arbiter, 2-cycle pipeline.
// Define LAYER_BLINK_EN for per-layer frame blinking.
module layer_priority_arbiter #(
  parameter int NUM_LAYERS   = 4,
  parameter int RGB_W        = 8,
  parameter int RANK_W       = 3
`ifdef LAYER_BLINK_EN
  , parameter int BLINK_FRAMES = 8
`endif
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            backGroundRGB,
`ifdef LAYER_BLINK_EN
  input  logic [NUM_LAYERS-1:0]       blinkMask,
`endif
  layer_priority_arbiter_if.slave     cfg,
  output logic [RGB_W-1:0]            RGBOut,
  output logic                        winValid,
  output logic [2:0]                  winLayer,
  output logic [NUM_LAYERS-2:0]       collisionFrame,
  output logic                        collisionPulse
);

  localparam int TW = NUM_LAYERS * RANK_W;

  function automatic logic [TW-1:0] def_tab();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      t[i*RANK_W +: RANK_W] = RANK_W'(i);
    return t;
  endfunction

  localparam logic [TW-1:0] DEF_TAB = def_tab();

  typedef enum logic {IDLE, PENDING} cfg_st_t;

  cfg_st_t st, st_nx;
  logic [TW-1:0] shadow, active;
  logic tab_ok, take, swap, bad, err_q;

  logic [NUM_LAYERS-1:0]       req_q, msk_q, arb_mask;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]            bg_q;
  logic [TW-1:0]               rank_q;

  logic [NUM_LAYERS-1:0] eff;
  logic                  sel_v;
  logic [2:0]            sel_i;
  logic [RANK_W-1:0]     sel_r;
  logic [RGB_W-1:0]      sel_rgb;

  logic [NUM_LAYERS-2:0] acc, cur_ov, frm_ov;

  assign cfg.cfg_ready = (st == IDLE);
  assign cfg.cfg_error = err_q;

  // table is legal when all ranks are in range and unique
  always_comb begin
    tab_ok = 1'b1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if ({1'b0, cfg.cfg_prio[i*RANK_W +: RANK_W]} >=
          (RANK_W+1)'(NUM_LAYERS))
        tab_ok = 1'b0;
      for (int j = i + 1; j < NUM_LAYERS; j++)
        if (cfg.cfg_prio[i*RANK_W +: RANK_W] ==
            cfg.cfg_prio[j*RANK_W +: RANK_W])
          tab_ok = 1'b0;
    end
  end

  // config FSM: accept into shadow, swap at frame start
  always_comb begin
    st_nx = st;
    take  = 1'b0;
    swap  = 1'b0;
    bad   = 1'b0;
    case (st)
      IDLE:
        if (cfg.cfg_valid) begin
          if (tab_ok) begin
            take  = 1'b1;
            st_nx = PENDING;
          end else begin
            bad = 1'b1;
          end
        end
      PENDING:
        if (startOfFrame) begin
          swap  = 1'b1;
          st_nx = IDLE;
        end
    endcase
  end

  // config state, shadow/active tables and error pulse
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      st     <= IDLE;
      shadow <= DEF_TAB;
      active <= DEF_TAB;
      err_q  <= 1'b0;
    end else begin
      st    <= st_nx;
      err_q <= bad;
      if (take) shadow <= cfg.cfg_prio;
      if (swap) active <= shadow;
    end
  end

`ifdef LAYER_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] frm_cnt;
  logic          blink_on;

  // frame counter; blink phase flips on every wrap
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      frm_cnt  <= '0;
      blink_on <= 1'b1;
    end else if (startOfFrame) begin
      if (frm_cnt == CW'(BLINK_FRAMES - 1)) begin
        frm_cnt  <= '0;
        blink_on <= ~blink_on;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign arb_mask = blink_on ? '0 : blinkMask;
`else
  assign arb_mask = '0;
`endif

  // stage 1: sample pixel inputs with the table/mask in force now
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      req_q  <= '0;
      msk_q  <= '0;
      rgb_q  <= '0;
      bg_q   <= '0;
      rank_q <= DEF_TAB;
    end else begin
      req_q  <= layerDrawingRequest;
      msk_q  <= arb_mask;
      rgb_q  <= layerRGB;
      bg_q   <= backGroundRGB;
      rank_q <= active;
    end
  end

  assign eff = req_q & ~msk_q;

  // lowest rank among unmasked requesters wins
  always_comb begin
    sel_v   = 1'b0;
    sel_i   = 3'd0;
    sel_r   = '0;
    sel_rgb = bg_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (eff[i] && (!sel_v || rank_q[i*RANK_W +: RANK_W] < sel_r)) begin
        sel_v   = 1'b1;
        sel_i   = 3'(i);
        sel_r   = rank_q[i*RANK_W +: RANK_W];
        sel_rgb = rgb_q[i*RGB_W +: RGB_W];
      end
    end
  end

  // stage 2: registered pixel outputs
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      RGBOut   <= '0;
      winValid <= 1'b0;
      winLayer <= 3'd0;
    end else begin
      RGBOut   <= sel_rgb;
      winValid <= sel_v;
      winLayer <= sel_i;
    end
  end

  assign cur_ov = req_q[NUM_LAYERS-1:1] & {(NUM_LAYERS-1){req_q[0]}};
  assign frm_ov = acc | cur_ov;

  // per-frame player overlap accumulation and report
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      acc            <= '0;
      collisionFrame <= '0;
      collisionPulse <= 1'b0;
    end else if (startOfFrame) begin
      acc            <= '0;
      collisionFrame <= frm_ov;
      collisionPulse <= |frm_ov;
    end else begin
      acc            <= frm_ov;
      collisionPulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Self-checking bench for layer_priority_arbiter.
// Vector table plus hand sequences, scoreboard on pixel outputs.
module tb_layer_priority_arbiter;

  localparam int NL = 4;
  localparam int RW = 8;
  localparam int KW = 3;

  logic              clk = 1'b0;
  logic              resetN = 1'b1;
  logic              sof = 1'b0;
  logic [NL-1:0]     req = '0;
  logic [NL*RW-1:0]  rgb = 32'h03E0AA1C;
  logic [RW-1:0]     bg = '0;
  logic [RW-1:0]     rgb_out;
  logic              win_v;
  logic [2:0]        win_l;
  logic [NL-2:0]     col;
  logic              col_p;
`ifdef LAYER_BLINK_EN
  logic [NL-1:0]     blink = '0;
`endif

  layer_priority_arbiter_if #(.NUM_LAYERS(NL), .RANK_W(KW)) cfg();

  layer_priority_arbiter #(
    .NUM_LAYERS(NL),
    .RGB_W(RW),
    .RANK_W(KW)
`ifdef LAYER_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(sof),
    .layerDrawingRequest(req),
    .layerRGB(rgb),
    .backGroundRGB(bg),
`ifdef LAYER_BLINK_EN
    .blinkMask(blink),
`endif
    .cfg(cfg),
    .RGBOut(rgb_out),
    .winValid(win_v),
    .winLayer(win_l),
    .collisionFrame(col),
    .collisionPulse(col_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] rgb;
    logic       v;
    logic [2:0] l;
  } sb_t;

  typedef struct {
    logic [3:0] req;
    logic [7:0] bg;
    logic [7:0] er;
    logic       ev;
    logic [2:0] el;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[8];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pr4(input int a0, input int a1,
                                      input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check($sformatf("pix@%0d", e.due),
            32'({rgb_out, win_v, win_l}), 32'({e.rgb, e.v, e.l}));
    end
  endtask

  task automatic px(input logic [3:0] r, input logic s, input logic cv,
                    input logic [11:0] pr, input logic ck,
                    input logic [7:0] er, input logic ev,
                    input logic [2:0] el);
    req = r;
    sof = s;
    cfg.cfg_valid = cv;
    cfg.cfg_prio = pr;
    if (ck) sb.push_back('{cyc + 2, er, ev, el});
    step();
  endtask

  task automatic pix(input logic [3:0] r, input logic [7:0] er,
                     input logic ev, input logic [2:0] el);
    px(r, 1'b0, 1'b0, 12'h0, 1'b1, er, ev, el);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      px(4'b0, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 3'd0);
  endtask

  task automatic frame_start(input logic [3:0] r);
    px(r, 1'b1, 1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b0101, 8'h00, 8'h1C, 1'b1, 3'd0};
    vt[1] = '{4'b0000, 8'h55, 8'h55, 1'b0, 3'd0};
    vt[2] = '{4'b0100, 8'h55, 8'hE0, 1'b1, 3'd2};
    vt[3] = '{4'b1000, 8'h55, 8'h03, 1'b1, 3'd3};
    vt[4] = '{4'b1110, 8'h55, 8'hAA, 1'b1, 3'd1};
    vt[5] = '{4'b1111, 8'h55, 8'h1C, 1'b1, 3'd0};
    vt[6] = '{4'b0010, 8'h66, 8'hAA, 1'b1, 3'd1};
    vt[7] = '{4'b1100, 8'h66, 8'hE0, 1'b1, 3'd2};

    cfg.cfg_valid = 1'b0;
    cfg.cfg_prio = '0;
    repeat (2) @(negedge clk);
    check("reset_state",
          32'({rgb_out, win_v, win_l, cfg.cfg_ready, cfg.cfg_error,
               col, col_p}),
          32'({8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0}));
    resetN = 1'b0;

    // default table arbitration
    for (int i = 0; i < 8; i++) begin
      bg = vt[i].bg;
      pix(vt[i].req, vt[i].er, vt[i].ev, vt[i].el);
    end
    bg = 8'h55;
    idle(2);

    frame_start(4'b0);
    check("col_tab", 32'(col), 32'(3'b111));
    check("pulse_tab", 32'(col_p), 32'(1));
    idle(1);
    check("pulse_off", 32'(col_p), 32'(0));
    check("col_hold", 32'(col), 32'(3'b111));

    // reversed table, applied at next frame start
    px(4'b0, 1'b0, 1'b1, pr4(3, 2, 1, 0), 1'b0, 8'h0, 1'b0, 3'd0);
    check("ready_pend", 32'(cfg.cfg_ready), 32'(0));
    check("err_ok", 32'(cfg.cfg_error), 32'(0));
    pix(4'b1001, 8'h1C, 1'b1, 3'd0);
    pix(4'b1001, 8'h1C, 1'b1, 3'd0);
    px(4'b1001, 1'b0, 1'b1, pr4(0, 0, 1, 2), 1'b1, 8'h1C, 1'b1, 3'd0);
    check("err_ign_pend", 32'(cfg.cfg_error), 32'(0));
    check("ready_still0", 32'(cfg.cfg_ready), 32'(0));
    px(4'b1001, 1'b1, 1'b0, 12'h0, 1'b1, 8'h1C, 1'b1, 3'd0);
    check("ready_back", 32'(cfg.cfg_ready), 32'(1));
    check("col_l3", 32'(col), 32'(3'b100));
    check("pulse_l3", 32'(col_p), 32'(1));
    pix(4'b1001, 8'h03, 1'b1, 3'd3);
    pix(4'b0011, 8'hAA, 1'b1, 3'd1);
    idle(2);

    // rejected tables
    px(4'b0, 1'b0, 1'b1, pr4(0, 0, 1, 2), 1'b0, 8'h0, 1'b0, 3'd0);
    check("err_dup", 32'(cfg.cfg_error), 32'(1));
    check("ready_dup", 32'(cfg.cfg_ready), 32'(1));
    idle(1);
    check("err_once", 32'(cfg.cfg_error), 32'(0));
    px(4'b0, 1'b0, 1'b1, pr4(4, 1, 2, 3), 1'b0, 8'h0, 1'b0, 3'd0);
    check("err_range", 32'(cfg.cfg_error), 32'(1));
    idle(1);
    pix(4'b1001, 8'h03, 1'b1, 3'd3);
    pix(4'b0110, 8'hE0, 1'b1, 3'd2);
    idle(2);

    // collision frame reporting
    frame_start(4'b0);
    repeat (3) pix(4'b0011, 8'hAA, 1'b1, 3'd1);
    idle(3);
    frame_start(4'b0);
    check("col_n", 32'(col), 32'(3'b001));
    check("pulse_n", 32'(col_p), 32'(1));
    idle(1);
    check("pulse_n_off", 32'(col_p), 32'(0));
    check("col_n_hold", 32'(col), 32'(3'b001));
    idle(2);
    frame_start(4'b0);
    check("col_n1", 32'(col), 32'(3'b000));
    check("pulse_n1", 32'(col_p), 32'(0));
    pix(4'b0011, 8'hAA, 1'b1, 3'd1);
    frame_start(4'b0);
    check("col_edge", 32'(col), 32'(3'b001));
    check("pulse_edge", 32'(col_p), 32'(1));
    idle(2);
    frame_start(4'b0);
    check("col_edge_next", 32'(col), 32'(3'b000));

    // reset while a table is pending and overlap is accumulated
    px(4'b0, 1'b0, 1'b1, pr4(2, 3, 1, 0), 1'b0, 8'h0, 1'b0, 3'd0);
    check("ready_pend2", 32'(cfg.cfg_ready), 32'(0));
    px(4'b0011, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 3'd0);
    px(4'b0011, 1'b0, 1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 3'd0);
    resetN = 1'b1;
    #1;
    check("mid_reset",
          32'({rgb_out, win_v, win_l, cfg.cfg_ready, cfg.cfg_error,
               col, col_p}),
          32'({8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 3'b000, 1'b0}));
    sb.delete();
    req = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    resetN = 1'b0;
    pix(4'b1010, 8'hAA, 1'b1, 3'd1);
    idle(2);
    frame_start(4'b0);
    check("col_after_rst", 32'(col), 32'(3'b000));
    check("pulse_after_rst", 32'(col_p), 32'(0));
    check("ready_after_rst", 32'(cfg.cfg_ready), 32'(1));
    pix(4'b1010, 8'hAA, 1'b1, 3'd1);
    idle(2);

`ifdef LAYER_BLINK_EN
    // blink: layer 0 hidden on frames 2-3 of each 4
    resetN = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    resetN = 1'b0;
    sb.delete();
    blink = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      logic on;
      on = ((f / 2) % 2) == 0;
      repeat (3)
        pix(4'b0011, on ? 8'h1C : 8'hAA, 1'b1, on ? 3'd0 : 3'd1);
      px(4'b0011, 1'b1, 1'b0, 12'h0, 1'b1,
         on ? 8'h1C : 8'hAA, 1'b1, on ? 3'd0 : 3'd1);
      check($sformatf("blink_col%0d", f), 32'({col, col_p}),
            32'({3'b001, 1'b1}));
    end
    idle(2);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
